// File: rtl/mem_copy_engine_if.sv
// Data-memory bus between the copy engine (master) and a word-addressed memory (slave).
// ReadData is registered by the memory on the falling edge while MemRead is high.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;

    modport master (
        output address,
        output MemRead,
        output MemWrite,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  address,
        input  MemRead,
        input  MemWrite,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternates one READ and one WRITE cycle per word,
// ascending addresses with modulo wrap, fully registered (Moore) outputs.
module mem_copy_engine #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [5:0]        word_count,
    output logic              busy,
    output logic              done,
    mem_copy_engine_if.master mem
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    state_t            state_q;
    logic [ADDR_W-1:0] srcAddr_q;
    logic [ADDR_W-1:0] dstAddr_q;
    logic [5:0]        remaining_q;

    logic [5:0]        countClamped_d;
    logic [ADDR_W-1:0] srcNext_d;
    logic [ADDR_W-1:0] dstNext_d;

    always_comb begin
        countClamped_d = (word_count > 6'd32) ? 6'd32 : word_count;
        srcNext_d      = srcAddr_q + WORD_STEP;
        dstNext_d      = dstAddr_q + WORD_STEP;
    end

    // WriteData doubles as the read buffer: it is loaded from ReadData on leaving READ
    // and is exactly what must be driven during WRITE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            srcAddr_q     <= '0;
            dstAddr_q     <= '0;
            remaining_q   <= '0;
            mem.address   <= '0;
            mem.WriteData <= '0;
            mem.MemRead   <= 1'b0;
            mem.MemWrite  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        srcAddr_q   <= src_addr & ALIGN_MASK;
                        dstAddr_q   <= dst_addr & ALIGN_MASK;
                        remaining_q <= countClamped_d;
                        if (countClamped_d != 6'd0) begin
                            state_q     <= READ;
                            mem.address <= src_addr & ALIGN_MASK;
                            mem.MemRead <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q       <= WRITE;
                    mem.WriteData <= mem.ReadData;
                    mem.address   <= dstAddr_q;
                    mem.MemRead   <= 1'b0;
                    mem.MemWrite  <= 1'b1;
                end
                WRITE: begin
                    srcAddr_q    <= srcNext_d;
                    dstAddr_q    <= dstNext_d;
                    remaining_q  <= remaining_q - 6'd1;
                    mem.MemWrite <= 1'b0;
                    if (remaining_q != 6'd1) begin
                        state_q     <= READ;
                        mem.address <= srcNext_d;
                        mem.MemRead <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural 32-word memory, a reference copy
// model feeding read/write scoreboard queues, and completion-timing checks.
module tb_mem_copy_engine;

    logic       clock;
    logic       reset;
    logic       start;
    logic [6:0] srcAddr;
    logic [6:0] dstAddr;
    logic [5:0] wordCount;
    logic       busy;
    logic       done;

    mem_copy_engine_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    mem_copy_engine #(.ADDR_W(7), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .src_addr   (srcAddr),
        .dst_addr   (dstAddr),
        .word_count (wordCount),
        .busy       (busy),
        .done       (done),
        .mem        (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] memArray  [32];
    logic [31:0] loadImage [32];
    logic [31:0] model     [32];
    logic        loadEn;

    logic [6:0]  expReads  [$];
    logic [38:0] expWrites [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Behavioural memory: bulk preload, falling-edge registered read, rising-edge write.
    always @(posedge clock) begin
        if (loadEn) begin
            for (int i = 0; i < 32; i++) memArray[i] <= loadImage[i];
        end else if (bus.MemWrite) begin
            memArray[int'(bus.address) >> 2] <= bus.WriteData;
        end
    end

    always @(negedge clock) begin
        if (bus.MemRead) bus.ReadData <= memArray[int'(bus.address) >> 2];
    end

    // Scoreboard monitor: every strobe must match the next expected transaction.
    always @(negedge clock) begin
        logic [6:0]  ra;
        logic [38:0] wx;
        if (!reset && (bus.MemRead || bus.MemWrite)) begin
            checkOutput("strobe_exclusive", 32'(bus.MemRead & bus.MemWrite), 32'd0);
            if (bus.MemRead) begin
                if (expReads.size() > 0) begin
                    ra = expReads.pop_front();
                    checkOutput("read_addr", 32'(bus.address), 32'(ra));
                end else begin
                    checkOutput("unexpected_read", 32'd1, 32'd0);
                end
            end
            if (bus.MemWrite) begin
                if (expWrites.size() > 0) begin
                    wx = expWrites.pop_front();
                    checkOutput("write_addr", 32'(bus.address), 32'(wx[38:32]));
                    checkOutput("write_data", bus.WriteData, wx[31:0]);
                end else begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end
            end
        end
    end

    task automatic loadMemory(input bit useRandom);
        for (int i = 0; i < 32; i++) begin
            loadImage[i] = useRandom ? $urandom : 32'(i + 32'h100);
            model[i]     = loadImage[i];
        end
        @(negedge clock);
        loadEn = 1'b1;
        @(negedge clock);
        loadEn = 1'b0;
    endtask

    // Reference copy: ascending order, no overlap correction, modulo-128 byte addresses.
    task automatic modelCopy(input logic [6:0] src, input logic [6:0] dst, input int n);
        logic [6:0] s;
        logic [6:0] d;
        s = src & 7'h7C;
        d = dst & 7'h7C;
        for (int i = 0; i < n; i++) begin
            expReads.push_back(s);
            expWrites.push_back({d, model[int'(s) >> 2]});
            model[int'(d) >> 2] = model[int'(s) >> 2];
            s = s + 7'd4;
            d = d + 7'd4;
        end
    endtask

    task automatic checkMemory(input string tag);
        for (int i = 0; i < 32; i++) checkOutput(tag, memArray[i], model[i]);
    endtask

    task automatic applyStimulus(input logic [6:0] src, input logic [6:0] dst,
                                 input int cnt, input bit pulseAgain);
        int n;
        int doneCycle;
        int busyCycles;
        n = (cnt > 32) ? 32 : cnt;
        modelCopy(src, dst, n);
        @(negedge clock);
        srcAddr   = src;
        dstAddr   = dst;
        wordCount = 6'(cnt);
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        srcAddr   = 7'h55;
        dstAddr   = 7'h2A;
        wordCount = 6'd7;
        doneCycle  = -1;
        busyCycles = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (pulseAgain && c == 10) start = 1'b1;
            if (pulseAgain && c == 11) start = 1'b0;
            if (busy) busyCycles++;
            if (done) begin
                doneCycle = c;
                break;
            end
        end
        checkOutput("done_cycle", 32'(doneCycle), 32'(2 * n + 1));
        checkOutput("busy_cycles", 32'(busyCycles), 32'(2 * n));
        @(negedge clock);
        checkOutput("done_single_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("reads_consumed", 32'(expReads.size()), 32'd0);
        checkOutput("writes_consumed", 32'(expWrites.size()), 32'd0);
    endtask

    task automatic applyMidCopyReset();
        int doneSeen;
        // Four words requested; reset lands in the WRITE cycle of word 2.
        modelCopy(7'h00, 7'h40, 1);
        expReads.push_back(7'h04);
        @(negedge clock);
        srcAddr   = 7'h00;
        dstAddr   = 7'h40;
        wordCount = 6'd4;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_address", 32'(bus.address), 32'd0);
        checkOutput("abort_wdata", bus.WriteData, 32'd0);
        checkOutput("abort_memread", 32'(bus.MemRead), 32'd0);
        checkOutput("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        doneSeen = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (done || busy) doneSeen++;
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
        checkOutput("abort_reads_consumed", 32'(expReads.size()), 32'd0);
        checkOutput("abort_writes_consumed", 32'(expWrites.size()), 32'd0);
        checkMemory("abort_mem");
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        srcAddr   = '0;
        dstAddr   = '0;
        wordCount = '0;
        loadEn    = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_address", 32'(bus.address), 32'd0);
        checkOutput("reset_wdata", bus.WriteData, 32'd0);
        checkOutput("reset_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'd0);
        checkOutput("reset_busy_done", 32'({busy, done}), 32'd0);
        reset = 1'b0;

        // Three-word copy from 0x00 to 0x40.
        loadMemory(1'b0);
        loadImage[0] = 32'h11; loadImage[1] = 32'h22; loadImage[2] = 32'h33;
        model[0] = 32'h11; model[1] = 32'h22; model[2] = 32'h33;
        @(negedge clock); loadEn = 1'b1;
        @(negedge clock); loadEn = 1'b0;
        applyStimulus(7'h00, 7'h40, 3, 1'b0);
        checkOutput("copy3_w0", memArray[16], 32'h11);
        checkOutput("copy3_w1", memArray[17], 32'h22);
        checkOutput("copy3_w2", memArray[18], 32'h33);
        checkMemory("copy3_mem");

        // Zero-length copy: no strobes, done in cycle 1.
        applyStimulus(7'h10, 7'h20, 0, 1'b0);

        // Address wrap on the source side.
        loadMemory(1'b1);
        applyStimulus(7'h7C, 7'h3C, 2, 1'b0);
        checkMemory("wrap_mem");

        // Byte-offset bits are ignored.
        applyStimulus(7'h05, 7'h0B, 1, 1'b0);
        checkMemory("align_mem");

        // Overlapping forward copy smears the first word.
        applyStimulus(7'h00, 7'h04, 3, 1'b0);
        checkMemory("overlap_mem");

        // Reset in the middle of a copy.
        loadMemory(1'b1);
        applyMidCopyReset();

        // Over-range count clamps to 32 words; a second start while busy is ignored.
        loadMemory(1'b1);
        applyStimulus(7'h00, 7'h40, 40, 1'b1);
        checkMemory("clamp_mem");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning byte-address width of the data-memory port (128 bytes, 32 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data-memory word width.
REQ-003 Port clock SHALL be an input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: copy request, sampled only in IDLE.
REQ-006 Port src_addr SHALL be an input, ADDR_W bits: source byte address; bits [1:0] ignored.
REQ-007 Port dst_addr SHALL be an input, ADDR_W bits: destination byte address; bits [1:0] ignored.
REQ-008 Port word_count SHALL be an input, 6 bits: number of words to copy, 0..32.
REQ-009 Port address SHALL be an output, ADDR_W bits: data-memory address.
REQ-010 Port MemRead SHALL be an output, 1 bit: data-memory read strobe.
REQ-011 Port MemWrite SHALL be an output, 1 bit: data-memory write strobe.
REQ-012 Port WriteData SHALL be an output, DATA_W bits: data-memory write data.
REQ-013 Port ReadData SHALL be an input, DATA_W bits: data-memory read data, registered by the memory on the falling clock edge while MemRead=1.
REQ-014 Port busy SHALL be an output, 1 bit: high while a copy is in progress.
REQ-015 Port done SHALL be an output, 1 bit: single-cycle completion pulse.

Function
REQ-016 All outputs SHALL be registered (Moore); FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-017 IDLE: start=1 at a rising edge SHALL latch src_addr, dst_addr (bits [1:0] forced to 0) and word_count, then go to READ if word_count!=0, else to DONE.
REQ-018 word_count values 33..63 SHALL be clamped to 32.
REQ-019 READ (one cycle): address=current src, MemRead=1, MemWrite=0; at the next rising edge the block SHALL capture ReadData into a DATA_W buffer and go to WRITE.
REQ-020 WRITE (one cycle): address=current dst, WriteData=buffer, MemWrite=1, MemRead=0; at the next rising edge src and dst SHALL each advance by 4, remaining count SHALL decrement, and the state SHALL go to READ if remaining>0, else to DONE.
REQ-021 Address increments SHALL wrap modulo 2^ADDR_W (0x7C+4 -> 0x00).
REQ-022 DONE (one cycle): done=1, busy=0, strobes 0; the state SHALL then go to IDLE.
REQ-023 busy SHALL be 1 exactly in READ and WRITE; MemRead and MemWrite SHALL never both be 1.
REQ-024 Throughput SHALL be 2 cycles per word; with start sampled at edge 0, done SHALL be high in cycle 2N+1 for N words (cycle 1 for N=0).
REQ-025 start asserted outside IDLE SHALL be ignored; start held high SHALL begin a new copy only when IDLE is re-entered.
REQ-026 Overlapping source/destination ranges SHALL be copied in ascending order with no overlap correction.
REQ-027 In IDLE and DONE, address and WriteData SHALL hold their last values; strobes SHALL be 0.

Reset
REQ-028 While reset=1, asynchronously, state SHALL be IDLE and address, WriteData, buffer, counters, MemRead, MemWrite, busy and done SHALL be 0.
REQ-029 Reset asserted mid-copy SHALL abort immediately with no further strobes; words already written SHALL remain, and no done pulse SHALL be generated.
REQ-030 After reset deassertion, the first start SHALL be sampled at the first subsequent rising edge.

Verification
REQ-031 Memory preloaded with words 0x11,0x22,0x33 at 0x00..0x08; start with src=0x00, dst=0x40, count=3 -> words at 0x40..0x48 = 0x11,0x22,0x33; done in cycle 7; busy in cycles 1-6.
REQ-032 Start with count=0 -> no MemRead or MemWrite; done in cycle 1.
REQ-033 Start with src=0x7C, dst=0x3C, count=2 -> reads 0x7C then 0x00; writes 0x3C then 0x40.
REQ-034 Start with src=0x05, dst=0x0B -> effective addresses 0x04 and 0x08.
REQ-035 Reset pulsed during WRITE of word 2 of 4 -> word 1 copied, words 2-4 untouched, all outputs 0, no done pulse.
REQ-036 Start re-pulsed while busy -> ignored; count=40 -> exactly 32 words copied, done in cycle 65.
